// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the serial nibble add/subtract unit.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/serial_nibble_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the serial adder.
interface serial_nibble_adder_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

endinterface

// File: rtl/serial_nibble_adder_fourbitadder.sv
// Team 4-bit ripple-carry adder slice; the serial adder reuses one instance every cycle.
module fourbitadder (
  input  logic       cin,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] S,
  output logic       Cout
);

  logic c;

  always_comb begin
    S = '0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// WIDTH-bit add/subtract computed one nibble per cycle, LSB first, on a shared 4-bit slice.
module serial_nibble_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  serial_nibble_adder_if.slave bus
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("serial_nibble_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                cout_nib;

  // Steer the current nibble of each operand into the shared slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
      end
    end
  end

  fourbitadder u_slice (
    .cin  (carry),
    .A    (a_nib),
    .B    (b_nib),
    .S    (s_nib),
    .Cout (cout_nib)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is A + ~B + 1: the +1 rides in on the initial carry.
            a_q        <= bus.in_a;
            b_q        <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry      <= bus.in_sub;
            idx        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) sum_q[NIBBLE_W*i +: NIBBLE_W] <= s_nib;
          end
          carry <= cout_nib;
          if (idx == LAST) begin
            idx         <= '0;
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry;
  assign bus.out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Self-checking bench: directed cases at WIDTH=16/4, random traffic at WIDTH=16/32 against an arithmetic model.
module tb_serial_nibble_adder;

  typedef struct {
    longint unsigned sum;
    bit              cout;
    bit              ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_on  = 0;
  int   acc16    = 0;
  int   acc32    = 0;
  exp_t q16[$];
  exp_t q32[$];

  serial_nibble_adder_if #(.WIDTH(16)) if16();
  serial_nibble_adder_if #(.WIDTH(32)) if32();
  serial_nibble_adder_if #(.WIDTH(4))  if4();

  serial_nibble_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  serial_nibble_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  serial_nibble_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands, signed range test for overflow.
  function automatic exp_t model(input int w, input longint unsigned a_in, input longint unsigned b_in, input bit sub);
    exp_t            e;
    longint unsigned mask;
    longint unsigned a;
    longint unsigned b;
    longint          lim;
    longint          sa;
    longint          sb;
    longint          r;
    mask   = (64'd1 << w) - 64'd1;
    a      = a_in & mask;
    b      = b_in & mask;
    lim    = longint'(64'd1 << (w - 1));
    sa     = ((a >> (w - 1)) & 64'd1) != 0 ? longint'(a) - 2 * lim : longint'(a);
    sb     = ((b >> (w - 1)) & 64'd1) != 0 ? longint'(b) - 2 * lim : longint'(b);
    r      = sub ? sa - sb : sa + sb;
    e.ovf  = (r >= lim) || (r < -lim);
    e.sum  = (sub ? a - b : a + b) & mask;
    e.cout = sub ? (a >= b) : (((a + b) >> w) & 64'd1) != 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=16 operation: latency, result, optional hold under backpressure, then release.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit sub,
                               input logic [15:0] es, input bit ec, input bit eo, input int hold);
    int k;
    @(posedge clk); #1;
    if16.in_a      = a;
    if16.in_b      = b;
    if16.in_sub    = sub;
    if16.in_valid  = 1'b1;
    if16.out_ready = 1'b0;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy_in_run", if16.busy, 1);
    checkOutput("in_ready_in_run", if16.in_ready, 0);
    k = 0;
    while (!if16.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("latency16", k, 4);
    checkOutput("sum16", if16.out_sum, es);
    checkOutput("cout16", if16.out_cout, ec);
    checkOutput("ovf16", if16.out_ovf, eo);
    checkOutput("busy_in_done", if16.busy, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if16.in_valid = 1'b1;
      if16.in_a     = 16'($urandom);
      if16.in_b     = 16'($urandom);
      if16.in_sub   = 1'($urandom);
      @(negedge clk);
      checkOutput("hold_valid", if16.out_valid, 1);
      checkOutput("hold_sum", if16.out_sum, es);
      checkOutput("hold_in_ready", if16.in_ready, 0);
    end
    @(posedge clk); #1;
    if16.in_valid  = 1'b1;
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("release_valid", if16.out_valid, 0);
    checkOutput("release_in_ready", if16.in_ready, 1);
    checkOutput("release_no_capture", if16.busy, 0);
  endtask

  // Scoreboards: every cycle a result is presented it must match the oldest accepted operation.
  always @(negedge clk) begin
    if (rand_on && !rst) begin
      if (if16.out_valid) begin
        checkOutput("w16_pending", q16.size(), 1);
        if (q16.size() > 0) begin
          checkOutput("w16_sum", if16.out_sum, q16[0].sum);
          checkOutput("w16_cout", if16.out_cout, q16[0].cout);
          checkOutput("w16_ovf", if16.out_ovf, q16[0].ovf);
          if (if16.out_ready) void'(q16.pop_front());
        end
      end
      if (if16.in_valid && if16.in_ready) begin
        q16.push_back(model(16, if16.in_a, if16.in_b, if16.in_sub));
        acc16++;
      end
    end
  end

  always @(negedge clk) begin
    if (rand_on && !rst) begin
      if (if32.out_valid) begin
        checkOutput("w32_pending", q32.size(), 1);
        if (q32.size() > 0) begin
          checkOutput("w32_sum", if32.out_sum, q32[0].sum);
          checkOutput("w32_cout", if32.out_cout, q32[0].cout);
          checkOutput("w32_ovf", if32.out_ovf, q32[0].ovf);
          if (if32.out_ready) void'(q32.pop_front());
        end
      end
      if (if32.in_valid && if32.in_ready) begin
        q32.push_back(model(32, if32.in_a, if32.in_b, if32.in_sub));
        acc32++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    exp_t e;
    int   k;
    int   guard;
    rst = 1'b1;
    if16.in_valid = 0; if16.in_a = '0; if16.in_b = '0; if16.in_sub = 0; if16.out_ready = 0;
    if32.in_valid = 0; if32.in_a = '0; if32.in_b = '0; if32.in_sub = 0; if32.out_ready = 0;
    if4.in_valid  = 0; if4.in_a  = '0; if4.in_b  = '0; if4.in_sub  = 0; if4.out_ready  = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", if16.out_valid, 0);
    checkOutput("rst_busy", if16.busy, 0);
    checkOutput("rst_out_sum", if16.out_sum, 0);
    checkOutput("rst_out_cout", if16.out_cout, 0);
    checkOutput("rst_out_ovf", if16.out_ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", if16.in_ready, 1);

    e = model(16, 'h7FFF, 'h0001, 0);
    checkOutput("model_add_ovf_sum", e.sum, 'h8000);
    checkOutput("model_add_ovf_flag", e.ovf, 1);
    e = model(16, 'h0005, 'h0007, 1);
    checkOutput("model_sub_borrow_sum", e.sum, 'hFFFE);
    checkOutput("model_sub_borrow_cout", e.cout, 0);
    e = model(32, 'hFFFF_FFFF, 'h1, 0);
    checkOutput("model_w32_wrap_sum", e.sum, 0);
    checkOutput("model_w32_wrap_cout", e.cout, 1);

    applyStimulus(16'h1234, 16'h4321, 0, 16'h5555, 0, 0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
    applyStimulus(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
    applyStimulus(16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0, 0);
    applyStimulus(16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 5);
    applyStimulus(16'hA5A5, 16'h0F0F, 0, 16'hB4B4, 0, 0, 0);

    // Asynchronous reset two cycles into an operation discards it.
    @(posedge clk); #1;
    if16.in_a = 16'h1111; if16.in_b = 16'h2222; if16.in_sub = 0; if16.in_valid = 1;
    @(posedge clk); #1;
    if16.in_valid = 0;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("pre_reset_busy", if16.busy, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", if16.out_valid, 0);
    checkOutput("async_rst_busy", if16.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", if16.in_ready, 1);
    checkOutput("post_rst_valid", if16.out_valid, 0);
    applyStimulus(16'h00FF, 16'h0001, 0, 16'h0100, 0, 0, 0);

    @(posedge clk); #1;
    if4.in_a = 4'hF; if4.in_b = 4'h1; if4.in_sub = 0; if4.in_valid = 1;
    @(posedge clk); #1;
    if4.in_valid = 0;
    k = 0;
    @(negedge clk);
    while (!if4.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    e = model(4, 'hF, 'h1, 0);
    checkOutput("latency4", k, 1);
    checkOutput("sum4", if4.out_sum, 4'h0);
    checkOutput("cout4", if4.out_cout, 1);
    checkOutput("ovf4", if4.out_ovf, e.ovf);
    @(posedge clk); #1 if4.out_ready = 1;
    @(posedge clk); #1 if4.out_ready = 0;

    rand_on = 1;
    fork
      begin
        guard = 0;
        while (acc16 < 1000 && guard < 40000) begin
          @(posedge clk); #1;
          if16.in_valid  = ($urandom_range(0, 3) != 0);
          if16.in_a      = 16'($urandom);
          if16.in_b      = 16'($urandom);
          if16.in_sub    = 1'($urandom);
          if16.out_ready = ($urandom_range(0, 3) != 0);
          guard++;
        end
        @(posedge clk); #1;
        if16.in_valid  = 0;
        if16.out_ready = 1;
      end
      begin
        int g32;
        g32 = 0;
        while (acc32 < 1000 && g32 < 40000) begin
          @(posedge clk); #1;
          if32.in_valid  = ($urandom_range(0, 3) != 0);
          if32.in_a      = $urandom;
          if32.in_b      = $urandom;
          if32.in_sub    = 1'($urandom);
          if32.out_ready = ($urandom_range(0, 3) != 0);
          g32++;
        end
        @(posedge clk); #1;
        if32.in_valid  = 0;
        if32.out_ready = 1;
      end
    join
    guard = 0;
    while ((q16.size() != 0 || q32.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    rand_on = 0;
    checkOutput("w16_ops_accepted", acc16, 1000);
    checkOutput("w32_ops_accepted", acc32, 1000);
    checkOutput("w16_drained", q16.size(), 0);
    checkOutput("w32_drained", q32.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
Name: serial_nibble_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit built on a single shared 4-bit ripple-carry adder slice.
- Each operation is split into WIDTH/4 nibbles, least significant first, one nibble per cycle; a carry register links the cycles.
- Upstream and downstream use valid/ready handshakes. Results are held until the consumer accepts them.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4 (elaboration-time assertion).
- NIB (localparam), WIDTH/4, number of nibble steps per operation.
- IDXW (localparam), max(1, $clog2(NIB)), width of the nibble index counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept an operation.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  final carry out; for subtract, 1 = no borrow.
- out_ovf  out  1  signed two's-complement overflow.
- busy  out  1  high while in the RUN state.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; idx, carry, operand registers and result register cleared; out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0; in_ready=1 once in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: a_q<=in_a; b_q<=in_sub ? ~in_b : in_b; carry<=in_sub; idx<=0; go to RUN.
- RUN:
  - busy=1, in_ready=0.
  - Slice inputs: a_q[4*idx+:4], b_q[4*idx+:4], carry.
  - Each cycle: sum_q[4*idx+:4]<=S; carry<=Cout; idx<=idx+1.
  - When idx==NIB-1, go to DONE.
- DONE:
  - out_valid=1; out_sum=sum_q; out_cout=carry.
  - out_ovf=(a_q[MSB]==b_q[MSB]) && (sum_q[MSB]!=a_q[MSB]), where b_q is the effective (possibly inverted) operand.
  - Outputs stay stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid falls on the next cycle.
- Latency: for an accept at edge E, out_valid is high in the cycle after edge E+NIB (4 cycles for WIDTH=16, 1 for WIDTH=4).
- Throughput: one operation per NIB+2 cycles. There is no IDLE bypass from DONE.
- Backpressure:
  - in_ready=0 in RUN and DONE.
  - in_valid is ignored in those states; operands are not captured.
- Simultaneous events:
  - out_ready high in the same cycle DONE is entered: handshake completes at the next edge.
  - in_valid asserted during DONE+out_ready: not accepted until the IDLE cycle.
- Reset mid-RUN or mid-DONE: the operation is discarded and no partial result is presented.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs except through state.
- Arithmetic is modulo 2^WIDTH. The carry register is 1 bit, and the index never exceeds NIB-1.

Decomposition:
- Package serial_add_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit logic;
  - NIBBLE_W=4.
- Sub-module: the team's existing 4-bit ripple adder fourbitadder, one instance.
  - Ports: cin, A[3:0], B[3:0] -> S[3:0], Cout.
- Nibble select/merge muxing and the FSM live in serial_nibble_adder.

Test Plan:
- Add, 0x1234+0x4321 -> out_sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Add, 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; then 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
- Sub, 0x0005-0x0007 -> sum=0xFFFE, cout=0 (borrow), ovf=0; then 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after result; pulse in_valid with other operands during that time -> result unchanged, in_ready=0, nothing captured; out_ready=1 -> IDLE next cycle, then new op accepted.
- Reset: assert rst asynchronously 2 cycles into RUN -> out_valid=0, busy=0 immediately; after release in_ready=1; next op 0x00FF+0x0001 -> 0x0100.
- WIDTH=4 instance: 0xF+0x1 -> sum=0x0, cout=1, 1-cycle latency; random 1000 ops vs reference model at WIDTH=16 and WIDTH=32.
